fp_norm_round: RTL and testbench

- Post-addition normalize/round stage of the FPU adder; sits directly downstream of the adder datapath's big mantissa ALU.
- Consumes the raw signed-magnitude sum: carry, hidden bit, fraction, and guard/round/sticky bits, plus the larger exponent and the result sign.
- Normalizes iteratively, one bit per cycle, then rounds to nearest-even and re-normalizes.
- Emits a packed IEEE-754 result over a valid/ready handshake.

---
 rtl/fp_norm_round_if.sv | 28 ++
 rtl/fp_norm_round.sv | 210 +++++++++++++++++++++
 tb/tb_fp_norm_round.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fp_norm_round_if.sv
// fp_norm_round_if: handshake and data bundle between the FPU adder's
// mantissa ALU (master) and the normalize/round stage (slave).
interface fp_norm_round_if #(
    parameter int N_float = 32,
    parameter int N_exp   = 8,
    parameter int N_mant  = 23
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic [N_exp-1:0]     in_exp;
    logic [N_mant+4:0]    in_mant;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_float-1:0]   float_R;
    logic                 out_overflow;
    logic                 out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, float_R, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, float_R, out_overflow, out_underflow
    );
endinterface

// File: rtl/fp_norm_round.sv
// fp_norm_round: post-addition normalize / round-to-nearest-even stage.
// Takes the raw signed-magnitude sum {carry, hidden, fraction, G, R, S},
// normalizes one bit per cycle, rounds, re-normalizes and packs an
// IEEE-754 result. Denormals are not produced: results below the minimum
// normal exponent flush to signed zero.
module fp_norm_round #(
    parameter int N_float = 32,
    parameter int N_exp   = 8,
    parameter int N_mant  = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_norm_round_if.slave  bus
);
    // Mantissa working width and exponent width with one spare bit for wrap detection
    localparam int MW = N_mant + 5;
    localparam int EW = N_exp + 1;

    localparam logic [EW-1:0] EXP_MAX = {1'b0, {N_exp{1'b1}}};
    localparam logic [EW-1:0] EXP_ONE = EW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_POST,
        S_DONE
    } state_t;

    state_t               r_state;
    logic                 r_sign;
    logic [EW-1:0]        r_exp;
    logic [MW-1:0]        r_mant;
    logic [N_float-1:0]   r_float;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_out_valid;

    state_t               w_state;
    logic                 w_sign;
    logic [EW-1:0]        w_exp;
    logic [MW-1:0]        w_mant;
    logic [N_float-1:0]   w_float;
    logic                 w_ovf;
    logic                 w_unf;
    logic                 w_out_valid;

    // Right shift by one; the bit shifted past round is folded into sticky
    function automatic logic [MW-1:0] f_shr_sticky(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        r    = {1'b0, m[MW-1:1]};
        r[0] = m[1] | m[0];
        return r;
    endfunction

    // Round to nearest, ties to even, at the fraction LSB (bit 3); G/R/S cleared
    function automatic logic [MW-1:0] f_round_rne(input logic [MW-1:0] m);
        logic          inc;
        logic [MW-1:0] r;
        inc = m[2] & (m[1] | m[0] | m[3]);
        r   = {m[MW-1:3], 3'b000};
        if (inc) begin
            r = r + {{(MW-4){1'b0}}, 4'b1000};
        end
        return r;
    endfunction

    // Signed infinity
    function automatic logic [N_float-1:0] f_inf(input logic s);
        return {s, {N_exp{1'b1}}, {N_mant{1'b0}}};
    endfunction

    // Signed zero
    function automatic logic [N_float-1:0] f_zero(input logic s);
        return {s, {(N_float-1){1'b0}}};
    endfunction

    // Pack sign, biased exponent and stored fraction
    function automatic logic [N_float-1:0] f_pack(input logic s,
                                                 input logic [N_exp-1:0] e,
                                                 input logic [N_mant-1:0] f);
        return {s, e, f};
    endfunction

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_mant      <= '0;
            r_float     <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_sign      <= w_sign;
            r_exp       <= w_exp;
            r_mant      <= w_mant;
            r_float     <= w_float;
            r_ovf       <= w_ovf;
            r_unf       <= w_unf;
            r_out_valid <= w_out_valid;
        end
    end

    // Next-state and next-datapath logic: one normalize/round action per cycle
    always_comb begin
        w_state     = r_state;
        w_sign      = r_sign;
        w_exp       = r_exp;
        w_mant      = r_mant;
        w_float     = r_float;
        w_ovf       = r_ovf;
        w_unf       = r_unf;
        w_out_valid = r_out_valid;

        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_sign = bus.in_sign;
                    w_exp  = {1'b0, bus.in_exp};
                    w_mant = bus.in_mant;
                    w_ovf  = 1'b0;
                    w_unf  = 1'b0;
                    if (&bus.in_exp) begin
                        w_float = f_inf(bus.in_sign);
                        w_ovf   = 1'b1;
                        w_state = S_DONE;
                    end else begin
                        w_state = S_NORM;
                    end
                end
            end

            S_NORM: begin
                if (r_mant == '0) begin
                    // Exact cancellation always yields +0
                    w_sign  = 1'b0;
                    w_float = f_zero(1'b0);
                    w_state = S_DONE;
                end else if (r_mant[MW-1]) begin
                    w_mant = f_shr_sticky(r_mant);
                    w_exp  = r_exp + EXP_ONE;
                    if (w_exp >= EXP_MAX) begin
                        w_float = f_inf(r_sign);
                        w_ovf   = 1'b1;
                        w_state = S_DONE;
                    end
                end else if (!r_mant[MW-2]) begin
                    // Exponent 1 is the smallest normal; one more shift would need a denormal
                    if (r_exp <= EXP_ONE) begin
                        w_float = f_zero(r_sign);
                        w_unf   = 1'b1;
                        w_state = S_DONE;
                    end else begin
                        w_mant = {r_mant[MW-2:0], 1'b0};
                        w_exp  = r_exp - EXP_ONE;
                    end
                end else begin
                    w_state = S_ROUND;
                end
            end

            S_ROUND: begin
                w_mant  = f_round_rne(r_mant);
                w_state = S_POST;
            end

            S_POST: begin
                if (r_mant[MW-1]) begin
                    // Rounding carried out of the hidden bit: fraction is all zeros here
                    w_mant = f_shr_sticky(r_mant);
                    w_exp  = r_exp + EXP_ONE;
                    if (w_exp >= EXP_MAX) begin
                        w_float = f_inf(r_sign);
                        w_ovf   = 1'b1;
                    end else begin
                        w_float = f_pack(r_sign, w_exp[N_exp-1:0], w_mant[N_mant+2:3]);
                    end
                end else begin
                    w_float = f_pack(r_sign, r_exp[N_exp-1:0], r_mant[N_mant+2:3]);
                end
                w_state = S_DONE;
            end

            S_DONE: begin
                // First DONE cycle raises valid; the transfer happens on a later cycle
                if (!r_out_valid) begin
                    w_out_valid = 1'b1;
                end else if (bus.out_ready) begin
                    w_out_valid = 1'b0;
                    w_state     = S_IDLE;
                end
            end

            default: begin
                w_state     = S_IDLE;
                w_out_valid = 1'b0;
            end
        endcase
    end

    assign bus.in_ready      = (r_state == S_IDLE);
    assign bus.out_valid     = r_out_valid;
    assign bus.float_R       = r_float;
    assign bus.out_overflow  = r_ovf;
    assign bus.out_underflow = r_unf;
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed-vector bench for the normalize/round stage.
module tb_fp_norm_round;
    localparam int NF = 32;
    localparam int NE = 8;
    localparam int NM = 23;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    fp_norm_round_if #(.N_float(NF), .N_exp(NE), .N_mant(NM)) bus();

    fp_norm_round #(.N_float(NF), .N_exp(NE), .N_mant(NM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Present one sum, let it be accepted, and count edges until out_valid rises
    task automatic run_op(input logic s, input logic [NE-1:0] e,
                          input logic [NM+4:0] m, output int lat);
        @(negedge clk);
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Let the transfer edge pass (out_ready assumed high)
    task automatic drain();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.float_R !== 32'h0) begin n_err++; $display("FAIL reset_float: got %h expected 00000000", bus.float_R); end
        n_cmp++; if ({bus.out_overflow, bus.out_underflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {bus.out_overflow, bus.out_underflow}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_carry_norm();
        int lat;
        run_op(1'b0, 8'h7F, 28'h8000000, lat);
        n_cmp++; if (lat != 5) begin n_err++; $display("FAIL carry_latency: got %0d expected 5", lat); end
        n_cmp++; if (bus.float_R !== 32'h40000000) begin n_err++; $display("FAIL carry_float: got %h expected 40000000", bus.float_R); end
        n_cmp++; if ({bus.out_overflow, bus.out_underflow} !== 2'b00) begin n_err++; $display("FAIL carry_flags: got %b expected 00", {bus.out_overflow, bus.out_underflow}); end
        drain();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL carry_valid_drop: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL carry_back_idle: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_cancellation();
        int lat;
        run_op(1'b0, 8'h7F, 28'h0000008, lat);
        n_cmp++; if (lat != 27) begin n_err++; $display("FAIL cancel_latency: got %0d expected 27", lat); end
        n_cmp++; if (bus.float_R !== 32'h34000000) begin n_err++; $display("FAIL cancel_float: got %h expected 34000000", bus.float_R); end
        drain();
    endtask

    task automatic test_zero();
        int lat;
        run_op(1'b1, 8'h7F, 28'h0000000, lat);
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL zero_latency: got %0d expected 2", lat); end
        n_cmp++; if (bus.float_R !== 32'h00000000) begin n_err++; $display("FAIL zero_float: got %h expected 00000000", bus.float_R); end
        n_cmp++; if (bus.out_underflow !== 1'b0) begin n_err++; $display("FAIL zero_underflow: got %b expected 0", bus.out_underflow); end
        drain();
    endtask

    task automatic test_round_even();
        logic [NM+4:0] vin [3];
        logic [NF-1:0] vexp [3];
        int lat;
        vin[0] = 28'h400000C; vexp[0] = 32'h3F800002;
        vin[1] = 28'h4000004; vexp[1] = 32'h3F800000;
        vin[2] = 28'h7FFFFFC; vexp[2] = 32'h40000000;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, 8'h7F, vin[i], lat);
            n_cmp++; if (lat != 4) begin n_err++; $display("FAIL round%0d_latency: got %0d expected 4", i, lat); end
            n_cmp++; if (bus.float_R !== vexp[i]) begin n_err++; $display("FAIL round%0d_float: got %h expected %h", i, bus.float_R, vexp[i]); end
            drain();
        end
    endtask

    task automatic test_inf_input();
        int lat;
        run_op(1'b0, 8'hFF, 28'h4000000, lat);
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL inf_latency: got %0d expected 1", lat); end
        n_cmp++; if (bus.float_R !== 32'h7F800000) begin n_err++; $display("FAIL inf_float: got %h expected 7F800000", bus.float_R); end
        n_cmp++; if (bus.out_overflow !== 1'b1) begin n_err++; $display("FAIL inf_overflow: got %b expected 1", bus.out_overflow); end
        drain();
    endtask

    task automatic test_overflow_backpressure();
        int lat;
        bus.out_ready = 1'b0;
        run_op(1'b1, 8'hFE, 28'h8000000, lat);
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL ovf_latency: got %0d expected 2", lat); end
        n_cmp++; if (bus.float_R !== 32'hFF800000) begin n_err++; $display("FAIL ovf_float: got %h expected FF800000", bus.float_R); end
        n_cmp++; if ({bus.out_overflow, bus.out_underflow} !== 2'b10) begin n_err++; $display("FAIL ovf_flags: got %b expected 10", {bus.out_overflow, bus.out_underflow}); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL hold%0d_valid: got %b expected 1", i, bus.out_valid); end
            n_cmp++; if (bus.float_R !== 32'hFF800000) begin n_err++; $display("FAIL hold%0d_float: got %h expected FF800000", i, bus.float_R); end
            n_cmp++; if (bus.out_overflow !== 1'b1) begin n_err++; $display("FAIL hold%0d_overflow: got %b expected 1", i, bus.out_overflow); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL hold%0d_in_ready: got %b expected 0", i, bus.in_ready); end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_release_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL ovf_release_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat;
        // Follows an overflow result: the new accept must clear the flag
        run_op(1'b1, 8'h80, 28'h4000000, lat);
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
        n_cmp++; if (bus.float_R !== 32'hC0000000) begin n_err++; $display("FAIL b2b_float: got %h expected C0000000", bus.float_R); end
        n_cmp++; if (bus.out_overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow: got %b expected 0", bus.out_overflow); end
        drain();
    endtask

    task automatic test_underflow_reset();
        int lat;
        run_op(1'b0, 8'h05, 28'h0000008, lat);
        n_cmp++; if (lat != 6) begin n_err++; $display("FAIL unf_latency: got %0d expected 6", lat); end
        n_cmp++; if (bus.float_R !== 32'h00000000) begin n_err++; $display("FAIL unf_float: got %h expected 00000000", bus.float_R); end
        n_cmp++; if ({bus.out_overflow, bus.out_underflow} !== 2'b01) begin n_err++; $display("FAIL unf_flags: got %b expected 01", {bus.out_overflow, bus.out_underflow}); end
        drain();
        // Leave a nonzero result in the output register before the reset
        run_op(1'b0, 8'h7F, 28'h8000000, lat);
        n_cmp++; if (bus.float_R !== 32'h40000000) begin n_err++; $display("FAIL pre_rst_float: got %h expected 40000000", bus.float_R); end
        drain();
        @(negedge clk);
        bus.in_sign  = 1'b0;
        bus.in_exp   = 8'h7F;
        bus.in_mant  = 28'h0000008;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_norm_busy: got %b expected 0", bus.in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.float_R !== 32'h0) begin n_err++; $display("FAIL rst_float: got %h expected 00000000", bus.float_R); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 8'h7F, 28'h8000000, lat);
        n_cmp++; if (lat != 5) begin n_err++; $display("FAIL post_rst_latency: got %0d expected 5", lat); end
        n_cmp++; if (bus.float_R !== 32'h40000000) begin n_err++; $display("FAIL post_rst_float: got %h expected 40000000", bus.float_R); end
        drain();
    endtask

    initial begin
        test_reset();
        test_carry_norm();
        test_cancellation();
        test_zero();
        test_round_even();
        test_inf_input();
        test_overflow_backpressure();
        test_back_to_back();
        test_underflow_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
